// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: PC register, combinational imem address, IF/ID capture register.
// Latency: imem address is zero-latency from the PC; fetched word lands in IF/ID one cycle later.
// Backpressure: i_stall holds PC and IF/ID; a redirect still wins over stall, a sticky fault freezes all.
//
// Ports:
//   i_clk, i_reset          clock and synchronous active-high reset
//   i_stall, i_flush        hazard-unit hold and IF/ID squash
//   i_br_taken, i_br_target branch redirect request and byte target
//   o_imem_address          byte address to instruction memory (= PC, combinational)
//   i_imem_instruction      word returned by instruction memory in the same cycle
//   o_ifid_valid/pc/instr   IF/ID pipeline register
//   o_fetch_fault           sticky misaligned / out-of-range flag, cleared only by reset
//   o_fetch_count, o_bubble_count  saturating perf counters, present only with FETCH_PERF_EN

module fetch_stage #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int unsigned IMEM_BYTES = 1024,
  parameter logic [31:0] NOP_WORD   = 32'hD503201F
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_br_taken,
  input  logic [63:0] i_br_target,
  output logic [63:0] o_imem_address,
  input  logic [31:0] i_imem_instruction,
  output logic        o_ifid_valid,
  output logic [63:0] o_ifid_pc,
  output logic [31:0] o_ifid_instr,
`ifdef FETCH_PERF_EN
  output logic [31:0] o_fetch_count,
  output logic [31:0] o_bubble_count,
`endif
  output logic        o_fetch_fault
);

  localparam logic [64:0] LP_LIMIT = 65'(IMEM_BYTES);

  logic [63:0] r_pc;
  logic        r_ifid_valid;
  logic [63:0] r_ifid_pc;
  logic [31:0] r_ifid_instr;
  logic        r_fault;

  logic [64:0] w_pc_last;
  logic        w_fault_now;
  logic [63:0] w_pc_inc;

  // Last byte of the word is computed in 65 bits so a PC near 2^64 cannot
  // wrap back into range and escape the fault check.
  assign w_pc_last   = {1'b0, r_pc} + 65'd3;
  assign w_fault_now = (r_pc[1:0] != 2'b00) || (w_pc_last >= LP_LIMIT);
  assign w_pc_inc    = r_pc + 64'd4;

  assign o_imem_address = r_pc;
  assign o_ifid_valid   = r_ifid_valid;
  assign o_ifid_pc      = r_ifid_pc;
  assign o_ifid_instr   = r_ifid_instr;
  assign o_fetch_fault  = r_fault;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc         <= RESET_PC;
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= 64'd0;
      r_ifid_instr <= NOP_WORD;
      r_fault      <= 1'b0;
    end else if (r_fault) begin
      // Frozen until reset; IF/ID already holds the bubble loaded on the fault.
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= 64'd0;
      r_ifid_instr <= NOP_WORD;
    end else if (i_br_taken) begin
      // Redirect beats stall so a taken branch is never lost behind a hazard.
      r_pc         <= i_br_target;
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= 64'd0;
      r_ifid_instr <= NOP_WORD;
    end else if (w_fault_now) begin
      r_fault      <= 1'b1;
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= 64'd0;
      r_ifid_instr <= NOP_WORD;
    end else if (i_stall) begin
      if (i_flush) begin
        r_ifid_valid <= 1'b0;
        r_ifid_pc    <= 64'd0;
        r_ifid_instr <= NOP_WORD;
      end
    end else if (i_flush) begin
      r_pc         <= w_pc_inc;
      r_ifid_valid <= 1'b0;
      r_ifid_pc    <= 64'd0;
      r_ifid_instr <= NOP_WORD;
    end else begin
      r_pc         <= w_pc_inc;
      r_ifid_valid <= 1'b1;
      r_ifid_pc    <= r_pc;
      r_ifid_instr <= i_imem_instruction;
    end
  end

`ifdef FETCH_PERF_EN
  logic        w_active;
  logic        w_capture;
  logic        w_bubble_load;
  logic [31:0] r_fetch_count;
  logic [31:0] r_bubble_count;

  // Mirrors the priority ladder above: capture is the normal branch, bubble
  // load is any branch that writes a fresh bubble (not the frozen-fault hold).
  assign w_active      = !r_fault;
  assign w_capture     = w_active && !i_br_taken && !w_fault_now && !i_stall && !i_flush;
  assign w_bubble_load = w_active && (i_br_taken || w_fault_now || i_flush);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fetch_count  <= 32'd0;
      r_bubble_count <= 32'd0;
    end else begin
      if (w_capture && (r_fetch_count != 32'hFFFFFFFF)) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_bubble_load && (r_bubble_count != 32'hFFFFFFFF)) begin
        r_bubble_count <= r_bubble_count + 32'd1;
      end
    end
  end

  assign o_fetch_count  = r_fetch_count;
  assign o_bubble_count = r_bubble_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        br_taken;
  logic [63:0] br_target;
  logic [63:0] imem_address;
  logic [31:0] imem_instruction;
  logic        ifid_valid;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        fetch_fault;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  int total = 0;
  int bad   = 0;

  // Word at byte address 4*i is 32'hA0000000 + i.
  logic [31:0] mem [0:255];

  assign imem_instruction = (imem_address < 64'd1024) ? mem[imem_address[9:2]] : 32'h0;

  fetch_stage #(
    .RESET_PC  (64'd0),
    .IMEM_BYTES(1024),
    .NOP_WORD  (32'hD503201F)
  ) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_stall           (stall),
    .i_flush           (flush),
    .i_br_taken        (br_taken),
    .i_br_target       (br_target),
    .o_imem_address    (imem_address),
    .i_imem_instruction(imem_instruction),
    .o_ifid_valid      (ifid_valid),
    .o_ifid_pc         (ifid_pc),
    .o_ifid_instr      (ifid_instr),
`ifdef FETCH_PERF_EN
    .o_fetch_count     (fetch_count),
    .o_bubble_count    (bubble_count),
`endif
    .o_fetch_fault     (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock, then settle 1 time unit past the edge before checking/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0; br_target = 64'd0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    stall = 1'b1; flush = 1'b1; br_taken = 1'b1; br_target = 64'h80;
    reset = 1'b1;
    step();
    step();
    total++; if (imem_address !== 64'd0) begin bad++; $display("FAIL reset_addr got=%h want=%h", imem_address, 64'd0); end
    total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", ifid_valid); end
    total++; if (ifid_pc !== 64'd0) begin bad++; $display("FAIL reset_pc got=%h want=0", ifid_pc); end
    total++; if (ifid_instr !== NOP) begin bad++; $display("FAIL reset_instr got=%h want=%h", ifid_instr, NOP); end
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b want=0", fetch_fault); end
    stall = 1'b0; flush = 1'b0; br_taken = 1'b0; br_target = 64'd0;
    reset = 1'b0;
  endtask

  task automatic test_straight_line();
    logic [63:0] exp_pc [0:3];
    logic [31:0] exp_w  [0:3];
    exp_pc[0] = 64'd0; exp_pc[1] = 64'd4; exp_pc[2] = 64'd8; exp_pc[3] = 64'd12;
    exp_w[0] = 32'hA0000000; exp_w[1] = 32'hA0000001; exp_w[2] = 32'hA0000002; exp_w[3] = 32'hA0000003;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step();
      total++; if (ifid_pc !== exp_pc[k]) begin bad++; $display("FAIL line_pc%0d got=%h want=%h", k, ifid_pc, exp_pc[k]); end
      total++; if (ifid_instr !== exp_w[k]) begin bad++; $display("FAIL line_instr%0d got=%h want=%h", k, ifid_instr, exp_w[k]); end
      total++; if (ifid_valid !== 1'b1) begin bad++; $display("FAIL line_valid%0d got=%b want=1", k, ifid_valid); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    step();
    step();
    // PC = 8, IF/ID = (4, W1)
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (imem_address !== 64'd8) begin bad++; $display("FAIL stall_addr%0d got=%h want=8", k, imem_address); end
      total++; if (ifid_pc !== 64'd4 || ifid_instr !== 32'hA0000001 || ifid_valid !== 1'b1) begin
        bad++; $display("FAIL stall_hold%0d got=%h/%h/%b want=4/a0000001/1", k, ifid_pc, ifid_instr, ifid_valid);
      end
    end
    stall = 1'b0;
    step();
    total++; if (ifid_pc !== 64'd8 || ifid_instr !== 32'hA0000002 || ifid_valid !== 1'b1) begin
      bad++; $display("FAIL stall_release got=%h/%h/%b want=8/a0000002/1", ifid_pc, ifid_instr, ifid_valid);
    end
  endtask

  task automatic test_redirect_stall();
    // continues from PC = 12
    total++; if (imem_address !== 64'd12) begin bad++; $display("FAIL redir_pre_addr got=%h want=c", imem_address); end
    stall = 1'b1; br_taken = 1'b1; br_target = 64'h40;
    step();
    total++; if (imem_address !== 64'h40) begin bad++; $display("FAIL redir_addr got=%h want=40", imem_address); end
    total++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP || ifid_pc !== 64'd0) begin
      bad++; $display("FAIL redir_bubble got=%b/%h/%h want=0/d503201f/0", ifid_valid, ifid_instr, ifid_pc);
    end
    stall = 1'b0; br_taken = 1'b0; br_target = 64'd0;
    step();
    total++; if (ifid_pc !== 64'h40 || ifid_instr !== 32'hA0000010 || ifid_valid !== 1'b1) begin
      bad++; $display("FAIL redir_target got=%h/%h/%b want=40/a0000010/1", ifid_pc, ifid_instr, ifid_valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    step();
    total++; if (imem_address !== 64'd4) begin bad++; $display("FAIL flush_pre_addr got=%h want=4", imem_address); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP || ifid_pc !== 64'd0) begin
      bad++; $display("FAIL flush_bubble got=%b/%h/%h want=0/d503201f/0", ifid_valid, ifid_instr, ifid_pc);
    end
    total++; if (imem_address !== 64'd8) begin bad++; $display("FAIL flush_addr got=%h want=8", imem_address); end
    step();
    total++; if (ifid_pc !== 64'd8 || ifid_instr !== 32'hA0000002) begin
      bad++; $display("FAIL flush_resume got=%h/%h want=8/a0000002", ifid_pc, ifid_instr);
    end
  endtask

  task automatic test_fault_branch();
    do_reset();
    br_taken = 1'b1; br_target = 64'h3FE;
    step();
    br_taken = 1'b0;
    total++; if (imem_address !== 64'h3FE) begin bad++; $display("FAIL fb_load_addr got=%h want=3fe", imem_address); end
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL fb_not_yet got=%b want=0", fetch_fault); end
    step();
    total++; if (fetch_fault !== 1'b1) begin bad++; $display("FAIL fb_rise got=%b want=1", fetch_fault); end
    total++; if (imem_address !== 64'h3FE || ifid_valid !== 1'b0) begin
      bad++; $display("FAIL fb_hold got=%h/%b want=3fe/0", imem_address, ifid_valid);
    end
    br_taken = 1'b1; br_target = 64'h40; flush = 1'b1;
    step();
    step();
    total++; if (fetch_fault !== 1'b1 || imem_address !== 64'h3FE || ifid_valid !== 1'b0) begin
      bad++; $display("FAIL fb_sticky got=%b/%h/%b want=1/3fe/0", fetch_fault, imem_address, ifid_valid);
    end
    // reset during a redirect request wins
    reset = 1'b1;
    step();
    reset = 1'b0; br_taken = 1'b0; flush = 1'b0;
    total++; if (fetch_fault !== 1'b0 || imem_address !== 64'd0) begin
      bad++; $display("FAIL fb_reset got=%b/%h want=0/0", fetch_fault, imem_address);
    end
  endtask

  task automatic test_fault_sequential();
    do_reset();
    br_taken = 1'b1; br_target = 64'h3F8;
    step();
    br_taken = 1'b0;
    step();
    total++; if (ifid_pc !== 64'h3F8 || ifid_instr !== 32'hA00000FE || fetch_fault !== 1'b0) begin
      bad++; $display("FAIL fs_3f8 got=%h/%h/%b want=3f8/a00000fe/0", ifid_pc, ifid_instr, fetch_fault);
    end
    step();
    total++; if (ifid_pc !== 64'h3FC || ifid_instr !== 32'hA00000FF || imem_address !== 64'h400) begin
      bad++; $display("FAIL fs_3fc got=%h/%h/%h want=3fc/a00000ff/400", ifid_pc, ifid_instr, imem_address);
    end
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL fs_pre got=%b want=0", fetch_fault); end
    step();
    total++; if (fetch_fault !== 1'b1 || imem_address !== 64'h400 || ifid_valid !== 1'b0) begin
      bad++; $display("FAIL fs_rise got=%b/%h/%b want=1/400/0", fetch_fault, imem_address, ifid_valid);
    end
    br_taken = 1'b1; br_target = 64'h0;
    step();
    br_taken = 1'b0;
    total++; if (fetch_fault !== 1'b1 || imem_address !== 64'h400) begin
      bad++; $display("FAIL fs_sticky got=%b/%h want=1/400", fetch_fault, imem_address);
    end
    do_reset();
    total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL fs_reset got=%b want=0", fetch_fault); end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_counters();
    do_reset();
    total++; if (fetch_count !== 32'd0 || bubble_count !== 32'd0) begin
      bad++; $display("FAIL cnt_reset got=%0d/%0d want=0/0", fetch_count, bubble_count);
    end
    for (int k = 0; k < 5; k++) step();
    flush = 1'b1; step(); flush = 1'b0;
    stall = 1'b1; step(); step(); stall = 1'b0;
    total++; if (fetch_count !== 32'd5) begin bad++; $display("FAIL cnt_fetch got=%0d want=5", fetch_count); end
    total++; if (bubble_count !== 32'd1) begin bad++; $display("FAIL cnt_bubble got=%0d want=1", bubble_count); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA0000000 + 32'(i);
    reset = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0; br_target = 64'd0;
    test_reset();
    test_straight_line();
    test_stall();
    test_redirect_stall();
    test_flush();
    test_fault_branch();
    test_fault_sequential();
`ifdef FETCH_PERF_EN
    test_counters();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined LEGv8 processor: owns the program counter, drives the byte address into the combinational instruction memory, and captures the returned 32-bit word into the IF/ID pipeline register. It applies hazard-unit stalls, branch redirects and flushes, and flags out-of-range or misaligned fetches. It sits between the branch/hazard logic and the decode stage.

## Interface
- RESET_PC, 64'd0: PC value loaded on reset; must be word-aligned.
- IMEM_BYTES, 1024: instruction memory size in bytes; power of two, greater than 4.
- NOP_WORD, 32'hD503201F: encoding inserted into IF/ID for bubbles.

- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit hold: PC and IF/ID keep their values.
- flush  in  1  squash the IF/ID contents to a bubble.
- br_taken  in  1  redirect request from the branch unit.
- br_target  in  64  redirect byte address.
- imem_address  out  64  byte address to the instruction memory; equals the PC, combinational.
- imem_instruction  in  32  word returned by the instruction memory in the same cycle.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_pc  out  64  PC of the IF/ID instruction.
- ifid_instr  out  32  IF/ID instruction word; NOP_WORD when invalid.
- fetch_fault  out  1  sticky: PC was misaligned or out of range.

## Operation
- Fault check on the current PC: fault_now = (pc[1:0] != 0) or (pc + 3 >= IMEM_BYTES). The comparison is unsigned and 64-bit, so a PC near 2^64 counts as out of range.
- Per-cycle priority, highest first:
  - reset: pc <= RESET_PC, ifid_valid <= 0, ifid_instr <= NOP_WORD, ifid_pc <= 0, fetch_fault <= 0.
  - fetch_fault already set: PC frozen, IF/ID is a bubble. Stall, flush and br_taken are ignored until reset.
  - br_taken: pc <= br_target. IF/ID becomes a bubble. This is accepted even when stall is high.
  - fault_now: fetch_fault <= 1, IF/ID becomes a bubble, PC held.
  - stall: PC and IF/ID hold. If flush is also high, IF/ID becomes a bubble and PC still holds.
  - flush only: pc <= pc + 4, IF/ID becomes a bubble.
  - normal: pc <= pc + 4, ifid_valid <= 1, ifid_pc <= pc, ifid_instr <= imem_instruction.
- Bubble definition: ifid_valid = 0, ifid_instr = NOP_WORD, ifid_pc = 0.
- PC increment is modulo 2^64. Wrap cannot be observed, because the range fault fires first.
- A misaligned br_target is loaded into the PC. It faults on the following cycle, and no IF/ID capture occurs.

## Timing
- imem_address is valid combinationally from the PC register, with zero added latency.
- Fetch-to-decode latency is 1 cycle: the word at PC in cycle N appears on ifid_instr after posedge N+1.
- Redirect penalty is 1 bubble: br_taken in cycle N means the target's word is valid in IF/ID after posedge N+2.
- All outputs are registered except imem_address.
- Reset values:
  - imem_address = RESET_PC
  - ifid_valid = 0
  - ifid_pc = 0
  - ifid_instr = NOP_WORD
  - fetch_fault = 0
- Reset asserted mid-stall or mid-redirect overrides everything on the same posedge.

## Configuration
- FETCH_PERF_EN defined: adds two 32-bit output counters.
  - fetch_count: increments on every normal capture.
  - bubble_count: increments on every cycle IF/ID is loaded with a bubble. Cycles where it merely holds an existing bubble do not count.
  - Both counters clear on reset and saturate at 32'hFFFFFFFF.
- FETCH_PERF_EN undefined: the counters and their ports do not exist. All other behaviour is identical.

## Test plan
- Straight-line fetch:
  - Stimulus: reset with RESET_PC=0, release, memory holds words W0..W3 at 0,4,8,12.
  - Required response: after posedges 1..4, ifid_pc = 0,4,8,12, ifid_instr = W0..W3, ifid_valid = 1.
- Stall:
  - Stimulus: stall high for 3 cycles at PC=8.
  - Required response: imem_address stays 8 and IF/ID keeps (4, W1). After release, IF/ID shows (8, W2).
- Redirect during stall:
  - Stimulus: stall=1, br_taken=1, br_target=0x40 at PC=12.
  - Required response: next cycle imem_address = 0x40 and ifid_valid = 0. One cycle later, IF/ID shows (0x40, mem[0x40]).
- Flush without stall:
  - Stimulus: at PC=4, flush=1 for one cycle.
  - Required response: IF/ID becomes a bubble (ifid_instr = 0xD503201F) and PC advances to 8.
- Faults:
  - Case 1: br_target = 0x3FE. Required: fetch_fault rises one cycle after the PC loads, the PC stays at 0x3FE, and fetch_fault stays set despite further br_taken until reset.
  - Case 2: sequential fetch reaching PC = 0x400. Required: the same fault behaviour.
- Counters, with FETCH_PERF_EN defined:
  - Stimulus: 5 normal fetches, 1 flush, 2 stall cycles.
  - Required response: fetch_count = 5, bubble_count = 1.
